// File: rtl/triangle_assembler_pkg.sv
// Shared definitions for the triangle assembler: FSM encoding, default widths
// and vertex field helpers also used by the rasterizer.
package triangle_assembler_pkg;

   localparam int ADDR_WIDTH_DEFAULT  = 8;
   localparam int COORD_WIDTH_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FETCH,
      ST_CAPTURE,
      ST_OUT,
      ST_DONE
   } state_e;

   function automatic int vertexWidth(input int coordWidth);
      return 3 * coordWidth;
   endfunction

   // A vertex word is {x, y, z} with x in the most significant bits.
   function automatic int xLsb(input int coordWidth);
      return 2 * coordWidth;
   endfunction

   function automatic int yLsb(input int coordWidth);
      return coordWidth;
   endfunction

   function automatic int zLsb(input int coordWidth);
      return 0 * coordWidth;
   endfunction

endpackage

// File: rtl/triangle_assembler_if.sv
// Triangle output channel between the assembler (master) and the rasterizer (slave).
interface triangle_assembler_if #(
   parameter int VERTEX_WIDTH = 48
);

   logic                    tri_valid;
   logic                    tri_ready;
   logic                    tri_last;
   logic [VERTEX_WIDTH-1:0] tri_v0;
   logic [VERTEX_WIDTH-1:0] tri_v1;
   logic [VERTEX_WIDTH-1:0] tri_v2;

   modport master (
      output tri_valid,
      output tri_last,
      output tri_v0,
      output tri_v1,
      output tri_v2,
      input  tri_ready
   );

   modport slave (
      input  tri_valid,
      input  tri_last,
      input  tri_v0,
      input  tri_v1,
      input  tri_v2,
      output tri_ready
   );

endinterface

// File: rtl/triangle_assembler_slot_regs.sv
// Three vertex slots written one at a time by index and read in parallel
// as the current triangle.
module triangle_slot_regs #(
   parameter int VERTEX_WIDTH = 48
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    we_i,
   input  logic [1:0]              idx_i,
   input  logic [VERTEX_WIDTH-1:0] wdata_i,
   output logic [VERTEX_WIDTH-1:0] v0_o,
   output logic [VERTEX_WIDTH-1:0] v1_o,
   output logic [VERTEX_WIDTH-1:0] v2_o
);

   logic [VERTEX_WIDTH-1:0] slot0_q;
   logic [VERTEX_WIDTH-1:0] slot1_q;
   logic [VERTEX_WIDTH-1:0] slot2_q;

   // Index 3 never occurs in normal operation and writes nothing.
   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         slot2_q <= '0;
      end else if (we_i) begin
         case (idx_i)
            2'd0:    slot0_q <= wdata_i;
            2'd1:    slot1_q <= wdata_i;
            2'd2:    slot2_q <= wdata_i;
            default: ;
         endcase
      end
   end

   assign v0_o = slot0_q;
   assign v1_o = slot1_q;
   assign v2_o = slot2_q;

endmodule

// File: rtl/triangle_assembler.sv
// Steps the vertex address generator, collects vertex words from the buffer
// and hands them to the rasterizer three at a time.
module triangle_assembler
   import triangle_assembler_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT,
   parameter int COORD_WIDTH  = COORD_WIDTH_DEFAULT,
   parameter int VERTEX_WIDTH = vertexWidth(COORD_WIDTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_i,
   output logic                    gen_rst_o,
   output logic                    increment_counter_o,
   input  logic                    gen_finish_i,
   input  logic [VERTEX_WIDTH-1:0] vertex_data_i,
   triangle_assembler_if.master    tri_if,
   output logic [ADDR_WIDTH-1:0]   tri_count_o,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    partial_err_o
);

   state_e                  state_q;
   logic [1:0]              idx_q;
   logic                    last_q;
   logic                    genRst_q;
   logic                    incr_q;
   logic                    triValid_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    partialErr_q;
   logic [ADDR_WIDTH-1:0]   triCount_q;
   logic                    slotWe;
   logic [VERTEX_WIDTH-1:0] slotV0;
   logic [VERTEX_WIDTH-1:0] slotV1;
   logic [VERTEX_WIDTH-1:0] slotV2;

   assign slotWe = (state_q == ST_CAPTURE);

   triangle_slot_regs #(
      .VERTEX_WIDTH(VERTEX_WIDTH)
   ) u_slots (
      .clk     (clk),
      .rst     (rst),
      .we_i    (slotWe),
      .idx_i   (idx_q),
      .wdata_i (vertex_data_i),
      .v0_o    (slotV0),
      .v1_o    (slotV1),
      .v2_o    (slotV2)
   );

   // Outputs are registered alongside the state so each pulse lines up with
   // the state it belongs to; the buffer word read in FETCH arrives in CAPTURE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         last_q       <= 1'b0;
         genRst_q     <= 1'b0;
         incr_q       <= 1'b0;
         triValid_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         partialErr_q <= 1'b0;
         triCount_q   <= '0;
      end else begin
         genRst_q <= 1'b0;
         incr_q   <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_q      <= ST_CLEAR;
                  genRst_q     <= 1'b1;
                  busy_q       <= 1'b1;
                  triCount_q   <= '0;
                  partialErr_q <= 1'b0;
                  idx_q        <= 2'd0;
               end
            end
            ST_CLEAR: begin
               state_q <= ST_FETCH;
               incr_q  <= 1'b1;
            end
            ST_FETCH: begin
               last_q  <= gen_finish_i;
               state_q <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               if (idx_q == 2'd2) begin
                  state_q    <= ST_OUT;
                  triValid_q <= 1'b1;
               end else if (last_q) begin
                  partialErr_q <= 1'b1;
                  state_q      <= ST_DONE;
                  done_q       <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 2'd1;
                  state_q <= ST_FETCH;
                  incr_q  <= 1'b1;
               end
            end
            ST_OUT: begin
               if (tri_if.tri_ready) begin
                  triValid_q <= 1'b0;
                  triCount_q <= triCount_q + 1'b1;
                  idx_q      <= 2'd0;
                  if (last_q) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_FETCH;
                     incr_q  <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gen_rst_o           = genRst_q;
   assign increment_counter_o = incr_q;
   assign tri_count_o         = triCount_q;
   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign partial_err_o       = partialErr_q;

   assign tri_if.tri_valid = triValid_q;
   assign tri_if.tri_last  = triValid_q & last_q;
   assign tri_if.tri_v0    = slotV0;
   assign tri_if.tri_v1    = slotV1;
   assign tri_if.tri_v2    = slotV2;

endmodule
